// File: rtl/nios_system_sysid_checker.sv
// Boot-time integrity sequencer for the sysid slave: reads ID and timestamp,
// compares against build constants, retries on mismatch, reports pass/fail.
//
// Optional feature macro: SYSID_CHECKER_IRQ_EN (adds irq / irq_ack ports).
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   start              single-cycle request to re-run check (IDLE/DONE only)
//   sysid_address      slave address (0 = ID, 1 = timestamp)
//   sysid_read         read strobe, one cycle per word
//   sysid_readdata     slave read data
//   id_value           last captured ID word
//   timestamp_value    last captured timestamp word
//   busy               high in every state except IDLE and DONE
//   done               check finished, held until next start or reset
//   pass / fail        result, valid only while done=1
//   retry_count        mismatch passes consumed in current run
//   irq / irq_ack      (SYSID_CHECKER_IRQ_EN only) failure interrupt + ack

module nios_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1489523336,
   parameter int          READ_LATENCY       = 0,
   parameter int          MAX_RETRIES        = 3,
   parameter int          AUTO_START         = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail,
`ifdef SYSID_CHECKER_IRQ_EN
   output logic [3:0]  retry_count,
   output logic        irq,
   input  logic        irq_ack
`else
   output logic [3:0]  retry_count
`endif
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_ID   = 3'd1;
   localparam logic [2:0] S_WAIT_ID = 3'd2;
   localparam logic [2:0] S_RD_TS   = 3'd3;
   localparam logic [2:0] S_WAIT_TS = 3'd4;
   localparam logic [2:0] S_CHECK   = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   localparam logic [2:0] LAT       = 3'(READ_LATENCY);
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);
   localparam bit         NO_WAIT   = (READ_LATENCY == 0);
   localparam bit         AUTO      = (AUTO_START != 0);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [1:0] lat_cnt;

   logic       lat_last;
   logic       words_ok;
   logic       cap_id;
   logic       cap_ts;
   logic       lat_inc;
   logic       retry_inc;
   logic       go_pass;
   logic       go_fail;
   logic       clr_res;

   // Last wait cycle: the sample lands READ_LATENCY cycles after the strobe.
   assign lat_last = ({1'b0, lat_cnt} + 3'd1) == LAT;

   assign words_ok = (id_value == EXPECTED_ID) &&
                     (timestamp_value == EXPECTED_TIMESTAMP);

   always_comb begin
      state_nxt = state;
      cap_id    = 1'b0;
      cap_ts    = 1'b0;
      lat_inc   = 1'b0;
      retry_inc = 1'b0;
      go_pass   = 1'b0;
      go_fail   = 1'b0;
      clr_res   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (AUTO || start) begin
               clr_res   = 1'b1;
               state_nxt = S_RD_ID;
            end
         end
         S_RD_ID: begin
            if (NO_WAIT) begin
               cap_id    = 1'b1;
               state_nxt = S_RD_TS;
            end else begin
               state_nxt = S_WAIT_ID;
            end
         end
         S_WAIT_ID: begin
            if (lat_last) begin
               cap_id    = 1'b1;
               state_nxt = S_RD_TS;
            end else begin
               lat_inc   = 1'b1;
            end
         end
         S_RD_TS: begin
            if (NO_WAIT) begin
               cap_ts    = 1'b1;
               state_nxt = S_CHECK;
            end else begin
               state_nxt = S_WAIT_TS;
            end
         end
         S_WAIT_TS: begin
            if (lat_last) begin
               cap_ts    = 1'b1;
               state_nxt = S_CHECK;
            end else begin
               lat_inc   = 1'b1;
            end
         end
         S_CHECK: begin
            if (words_ok) begin
               go_pass   = 1'b1;
               state_nxt = S_DONE;
            end else if (retry_count != RETRY_MAX) begin
               retry_inc = 1'b1;
               state_nxt = S_RD_ID;
            end else begin
               go_fail   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               clr_res   = 1'b1;
               state_nxt = S_RD_ID;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= S_IDLE;
         lat_cnt         <= 2'd0;
         sysid_address   <= 1'b0;
         sysid_read      <= 1'b0;
         id_value        <= 32'd0;
         timestamp_value <= 32'd0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         fail            <= 1'b0;
         retry_count     <= 4'd0;
      end else begin
         state <= state_nxt;

         // Counter restarts on every strobe cycle, counts through waits.
         if (state == S_RD_ID || state == S_RD_TS)
            lat_cnt <= 2'd0;
         else if (lat_inc)
            lat_cnt <= lat_cnt + 2'd1;

         if (cap_id)
            id_value <= sysid_readdata;
         if (cap_ts)
            timestamp_value <= sysid_readdata;

         // Outputs are registered from the next state so they line up
         // with the state they describe.
         sysid_read <= (state_nxt == S_RD_ID) || (state_nxt == S_RD_TS);
         if (state_nxt == S_RD_ID)
            sysid_address <= 1'b0;
         else if (state_nxt == S_RD_TS)
            sysid_address <= 1'b1;
         busy <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);

         if (clr_res) begin
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            retry_count <= 4'd0;
         end
         if (retry_inc)
            retry_count <= retry_count + 4'd1;
         if (go_pass) begin
            done <= 1'b1;
            pass <= 1'b1;
         end
         if (go_fail) begin
            done <= 1'b1;
            fail <= 1'b1;
         end
      end
   end

`ifdef SYSID_CHECKER_IRQ_EN
   // Set has priority over ack; a new start leaves irq untouched.
   always_ff @(posedge clock) begin
      if (reset)
         irq <= 1'b0;
      else if (go_fail)
         irq <= 1'b1;
      else if (irq_ack)
         irq <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Randomized scoreboard bench for nios_system_sysid_checker.
// Two instances: auto-start with latency 2, and manual start with latency 0.

module tb_nios_system_sysid_checker;

   localparam int          LAT    = 2;
   localparam int          MR     = 3;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1489523336;
   localparam logic [31:0] B_ID   = 32'hA5A5_0001;
   localparam logic [31:0] B_TS   = 32'h0000_1234;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // instance A
   logic        rst, start;
   logic        addr, rd;
   logic [31:0] rdata, idv, tsv;
   logic        busy, done, pass, fail;
   logic [3:0]  rc;
   // instance B
   logic        rst_b, start_b;
   logic        addr_b, rd_b;
   logic [31:0] rdata_b, idv_b, tsv_b;
   logic        busy_b, done_b, pass_b, fail_b;
   logic [3:0]  rc_b;
`ifdef SYSID_CHECKER_IRQ_EN
   logic        irq, irq_ack, irq_b;
   logic        irq_ack_b = 1'b0;
`endif

   nios_system_sysid_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
      .READ_LATENCY(LAT), .MAX_RETRIES(MR), .AUTO_START(1)
   ) dut (
      .clock(clk), .reset(rst), .start(start),
      .sysid_address(addr), .sysid_read(rd), .sysid_readdata(rdata),
      .id_value(idv), .timestamp_value(tsv), .busy(busy),
      .done(done), .pass(pass), .fail(fail),
`ifdef SYSID_CHECKER_IRQ_EN
      .retry_count(rc), .irq(irq), .irq_ack(irq_ack)
`else
      .retry_count(rc)
`endif
   );

   nios_system_sysid_checker #(
      .EXPECTED_ID(B_ID), .EXPECTED_TIMESTAMP(B_TS),
      .READ_LATENCY(0), .MAX_RETRIES(0), .AUTO_START(0)
   ) dut_b (
      .clock(clk), .reset(rst_b), .start(start_b),
      .sysid_address(addr_b), .sysid_read(rd_b), .sysid_readdata(rdata_b),
      .id_value(idv_b), .timestamp_value(tsv_b), .busy(busy_b),
      .done(done_b), .pass(pass_b), .fail(fail_b),
`ifdef SYSID_CHECKER_IRQ_EN
      .retry_count(rc_b), .irq(irq_b), .irq_ack(irq_ack_b)
`else
      .retry_count(rc_b)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // ---------------- slave model for A ----------------
   // Bad-pass counts: the first bad_id_n ID reads (and bad_ts_n TS reads)
   // of a run return a wrong word; later reads return the good word.
   int          bad_id_n, bad_ts_n;
   logic [31:0] bad_id_v, bad_ts_v;
   int          id_cnt, ts_cnt, strobes;
   logic        pv  [0:LAT];
   logic        pa  [0:LAT];
   int          pix [0:LAT];

   function automatic logic [31:0] word(input logic a, input int idx);
      if (a) return (idx < bad_ts_n) ? bad_ts_v : EXP_TS;
      return (idx < bad_id_n) ? bad_id_v : EXP_ID;
   endfunction

   // Data is valid only LAT cycles after the strobe; garbage otherwise.
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i <= LAT; i++) pv[i] = 1'b0;
         rdata = $urandom;
      end else begin
         for (int i = LAT; i > 0; i--) begin
            pv[i]  = pv[i-1];
            pa[i]  = pa[i-1];
            pix[i] = pix[i-1];
         end
         pv[0]  = rd;
         pa[0]  = addr;
         pix[0] = addr ? ts_cnt : id_cnt;
         if (rd) begin
            strobes++;
            if (addr) ts_cnt++;
            else      id_cnt++;
         end
         rdata = pv[LAT] ? word(pa[LAT], pix[LAT]) : $urandom;
      end
   end

   // ---------------- scoreboard for A ----------------
   typedef struct {
      bit          ps;
      bit          fl;
      int          rcnt;
      logic [31:0] id;
      logic [31:0] ts;
      int          nstr;
   } exp_t;

   exp_t q[$];

   function automatic exp_t model(input int bi, input int bt,
                                  input logic [31:0] vi,
                                  input logic [31:0] vt);
      exp_t e;
      int   k;
      k = (bi > bt) ? bi : bt;
      if (k <= MR) begin
         e = '{1'b1, 1'b0, k, EXP_ID, EXP_TS, 2 * (k + 1)};
      end else begin
         e.ps   = 1'b0;
         e.fl   = 1'b1;
         e.rcnt = MR;
         e.id   = (MR < bi) ? vi : EXP_ID;
         e.ts   = (MR < bt) ? vt : EXP_TS;
         e.nstr = 2 * (MR + 1);
      end
      return e;
   endfunction

   logic done_q = 1'b0;
   always @(negedge clk) begin
      if (done && !done_q) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done at %0t", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pass",    32'(pass), 32'(e.ps));
            chk("fail",    32'(fail), 32'(e.fl));
            chk("retry",   32'(rc),   32'(e.rcnt));
            chk("id",      idv,       e.id);
            chk("ts",      tsv,       e.ts);
            chk("strobes", 32'(strobes), 32'(e.nstr));
            chk("excl",    32'(pass && fail), 32'd0);
         end
      end
      done_q = done;
   end

   // ---------------- slave for B (combinational) ----------------
   logic b_bad = 1'b0;
   int   strobes_b = 0;
   assign rdata_b = !rd_b ? 32'hDEAD_BEEF :
                    addr_b ? (b_bad ? ~B_TS : B_TS) : B_ID;
   always @(negedge clk) if (!rst_b && rd_b) strobes_b++;

   // ---------------- helpers ----------------
   task automatic wait_done(input bit which, input int lim);
      int k;
      for (k = 0; k < lim; k++) begin
         @(negedge clk);
         if (which ? done_b : done) break;
      end
      if (k == lim) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout_done_%0d at %0t", which, $time);
      end
      @(negedge clk);
   endtask

   task automatic set_scn(input int bi, input int bt);
      bad_id_n = bi;
      bad_ts_n = bt;
      bad_id_v = EXP_ID ^ ($urandom | 32'd1);
      bad_ts_v = EXP_TS ^ ($urandom | 32'd1);
      id_cnt   = 0;
      ts_cnt   = 0;
      strobes  = 0;
   endtask

   task automatic push_scn();
      q.push_back(model(bad_id_n, bad_ts_n, bad_id_v, bad_ts_v));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_done"}, 32'(done), 32'd0);
      chk({nm, "_pf"},   32'(pass | fail), 32'd0);
      chk({nm, "_rd"},   32'({rd, addr}), 32'd0);
      chk({nm, "_id"},   idv, 32'd0);
      chk({nm, "_ts"},   tsv, 32'd0);
      chk({nm, "_rc"},   32'(rc), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] prev_id;
      int          k;
      rst     = 1'b1;
      start   = 1'b0;
      rst_b   = 1'b1;
      start_b = 1'b0;
`ifdef SYSID_CHECKER_IRQ_EN
      irq_ack = 1'b0;
`endif
      set_scn(0, 0);
      repeat (3) @(negedge clk);
      chk_zero("reset");
      push_scn();
      rst   = 1'b0;
      rst_b = 1'b0;
      wait_done(1'b0, 100);

      // directed: wrong ID on first pass only, then forced TS failure
      set_scn(1, 0);
      push_scn();
      pulse_start();
      wait_done(1'b0, 200);

      prev_id = idv;
      set_scn(0, 9);
      bad_ts_v = 32'h1234_5678;
      push_scn();
      pulse_start();
      chk("start_clears_done", 32'(done), 32'd0);
      chk("start_keeps_id", idv, prev_id);
      wait_done(1'b0, 200);
`ifdef SYSID_CHECKER_IRQ_EN
      chk("irq_on_fail", 32'(irq), 32'd1);
      set_scn(0, 0);
      push_scn();
      pulse_start();
      wait_done(1'b0, 200);
      chk("irq_held", 32'(irq), 32'd1);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      chk("irq_ack", 32'(irq), 32'd0);
`endif

      // random runs, some with an ignored start pulse mid-run
      for (int r = 0; r < 12; r++) begin
         set_scn($urandom_range(0, 5), $urandom_range(0, 5));
         if (r % 3 == 0) bad_ts_n = 0;
         push_scn();
         pulse_start();
         if (r % 2 == 1) begin
            repeat (2) @(negedge clk);
            pulse_start();
         end
         wait_done(1'b0, 400);
      end

      // reset while waiting on the timestamp word
      set_scn(4, 4);
      pulse_start();
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (busy && addr && !rd) break;
      end
      if (k == 50) chk("reach_wait_ts", 32'd0, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      set_scn(2, 0);
      push_scn();
      rst = 1'b0;
      @(negedge clk);
      chk("rerun_rc0", 32'(rc), 32'd0);
      chk("rerun_busy", 32'(busy), 32'd1);
      wait_done(1'b0, 300);

      // instance B: manual start, no strobes until asked
      chk("b_nostrobe", 32'(strobes_b), 32'd0);
      chk("b_idle", 32'(busy_b | done_b), 32'd0);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      wait_done(1'b1, 20);
      chk("b_pass", 32'(pass_b), 32'd1);
      chk("b_strobes", 32'(strobes_b), 32'd2);
      chk("b_rc", 32'(rc_b), 32'd0);
      chk("b_id", idv_b, B_ID);
      b_bad     = 1'b1;
      strobes_b = 0;
      start_b   = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      wait_done(1'b1, 20);
      chk("b_fail", 32'({pass_b, fail_b}), 32'd1);
      chk("b_fail_strobes", 32'(strobes_b), 32'd2);
      chk("b_ts", tsv_b, ~B_TS);
`ifdef SYSID_CHECKER_IRQ_EN
      chk("b_irq", 32'(irq_b), 32'd1);
`endif

      if (q.size() != 0) chk("sb_leftover", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
